// File: rtl/ui_pkg.sv
// Shared constants and types for the UI point capture / segment queue.
package ui_pkg;

    localparam int unsigned UI_X_W = 9;
    localparam int unsigned UI_Y_W = 8;
    localparam int unsigned UI_C_W = 3;

    typedef enum logic {
        MODE_SEG  = 1'b0,
        MODE_POLY = 1'b1
    } ui_mode_e;

endpackage

// File: rtl/ui_point_fifo.sv
// Point FIFO with a two-entry peek at head and head+1, pop-by-1 or pop-by-2.
// The caller guarantees it never pushes into a full FIFO without a same-cycle pop.
module ui_point_fifo #(
    parameter int unsigned W     = 20,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop1,
    input  logic          pop2,
    output logic [W-1:0]  head0,
    output logic [W-1:0]  head1,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] rd_next;
    logic [CW-1:0] pop_n;

    always_comb begin
        pop_n = '0;
        if (pop2) begin
            pop_n = CW'(2);
        end else if (pop1) begin
            pop_n = CW'(1);
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    assign rd_next = rd_ptr_q + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            rd_ptr_q <= rd_ptr_q + PW'(pop_n);
            count_q  <= count_q - pop_n + CW'(push);
        end
    end

    assign head0 = mem_q[rd_ptr_q];
    assign head1 = mem_q[rd_next];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/ui_point_queue.sv
// Stages x/y/colour from the switch bus, queues points and presents line
// segments (disjoint or polyline) to the line engine over valid/ready.
module ui_point_queue
    import ui_pkg::*;
#(
    parameter int unsigned X_W   = UI_X_W,
    parameter int unsigned Y_W   = UI_Y_W,
    parameter int unsigned C_W   = UI_C_W,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned W    = X_W + Y_W + C_W,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic [X_W-1:0] i_val,
    input  logic           i_setx,
    input  logic           i_sety,
    input  logic           i_setcol,
    input  logic           i_push,
    input  logic           i_flush,
    input  logic           i_mode,
    input  logic           i_ready,
    output logic [X_W-1:0] o_xin,
    output logic [Y_W-1:0] o_yin,
    output logic [C_W-1:0] o_cin,
    output logic           o_valid,
    output logic [X_W-1:0] o_x0,
    output logic [Y_W-1:0] o_y0,
    output logic [X_W-1:0] o_x1,
    output logic [Y_W-1:0] o_y1,
    output logic [C_W-1:0] o_color,
    output logic [CW-1:0]  o_count,
    output logic           o_full,
    output logic           o_empty,
    output logic           o_drop
);

    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic [C_W-1:0] c_q;
    logic           drop_q;

    logic [W-1:0]   head0;
    logic [W-1:0]   head1;
    logic [CW-1:0]  count;
    logic           full;
    logic           empty;
    logic           valid;
    logic           pop;
    logic           pop1;
    logic           pop2;
    logic           push_ok;
    ui_mode_e       mode;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            x_q <= '0;
            y_q <= '0;
            c_q <= '0;
        end else begin
            if (i_setx) begin
                x_q <= i_val;
            end
            if (i_sety) begin
                y_q <= i_val[Y_W-1:0];
            end
            if (i_setcol) begin
                c_q <= i_val[C_W-1:0];
            end
        end
    end

    assign mode  = ui_mode_e'(i_mode);
    assign valid = (count >= CW'(2));
    assign pop   = valid & i_ready & ~i_flush;
    assign pop1  = pop & (mode == MODE_POLY);
    assign pop2  = pop & (mode == MODE_SEG);

    // A pop in the same cycle always frees at least one slot for the push.
    assign push_ok = i_push & ~i_flush & (~full | pop);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= i_push & ~i_flush & full & ~pop;
        end
    end

    ui_point_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .flush (i_flush),
        .push  (push_ok),
        .wdata ({x_q, y_q, c_q}),
        .pop1  (pop1),
        .pop2  (pop2),
        .head0 (head0),
        .head1 (head1),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // The start point's colour is not presented; only the end colour is.
    logic unused_head0_c;
    assign unused_head0_c = ^head0[C_W-1:0];

    assign o_xin   = x_q;
    assign o_yin   = y_q;
    assign o_cin   = c_q;
    assign o_valid = valid;
    assign o_x0    = head0[W-1 -: X_W];
    assign o_y0    = head0[C_W +: Y_W];
    assign o_x1    = head1[W-1 -: X_W];
    assign o_y1    = head1[C_W +: Y_W];
    assign o_color = head1[C_W-1:0];
    assign o_count = count;
    assign o_full  = full;
    assign o_empty = empty;
    assign o_drop  = drop_q;

endmodule

// File: tb/tb_ui_point_queue.sv
// Self-checking bench for ui_point_queue: directed table, corner sequences and
// a random phase, all checked against a queue-based reference model.
module tb_ui_point_queue;
    import ui_pkg::*;

    localparam int DEPTH = 4;

    logic       i_clk = 1'b0;
    logic       i_reset_n;
    logic [8:0] i_val;
    logic       i_setx, i_sety, i_setcol, i_push, i_flush, i_mode, i_ready;
    logic [8:0] o_xin, o_x0, o_x1;
    logic [7:0] o_yin, o_y0, o_y1;
    logic [2:0] o_cin, o_color, o_count;
    logic       o_valid, o_full, o_empty, o_drop;

    ui_point_queue #(
        .X_W   (9),
        .Y_W   (8),
        .C_W   (3),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_val     (i_val),
        .i_setx    (i_setx),
        .i_sety    (i_sety),
        .i_setcol  (i_setcol),
        .i_push    (i_push),
        .i_flush   (i_flush),
        .i_mode    (i_mode),
        .i_ready   (i_ready),
        .o_xin     (o_xin),
        .o_yin     (o_yin),
        .o_cin     (o_cin),
        .o_valid   (o_valid),
        .o_x0      (o_x0),
        .o_y0      (o_y0),
        .o_x1      (o_x1),
        .o_y1      (o_y1),
        .o_color   (o_color),
        .o_count   (o_count),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_drop    (o_drop)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } pt_t;

    typedef struct {
        logic       setx;
        logic       sety;
        logic       setcol;
        logic [8:0] val;
        logic       push;
        logic       ev;
        int         ecnt;
        int         ex0;
        int         ey0;
        int         ex1;
        int         ey1;
        int         ec;
    } vec_t;

    pt_t        mq[$];
    logic [8:0] sx;
    logic [7:0] sy;
    logic [2:0] sc;
    int         n_cmp = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        i_setx = 0; i_sety = 0; i_setcol = 0; i_val = '0;
        i_push = 0; i_flush = 0; i_mode = 0; i_ready = 0;
    endtask

    // One clock: drive inputs, check pre-edge state against the model, advance.
    task automatic cyc(input logic setx, input logic sety, input logic setcol,
                       input logic [8:0] val, input logic push, input logic flush,
                       input logic mode, input logic ready);
        int   popped;
        logic accept;
        logic drop_e;
        i_setx = setx; i_sety = sety; i_setcol = setcol; i_val = val;
        i_push = push; i_flush = flush; i_mode = mode; i_ready = ready;
        chk("valid", o_valid, mq.size() >= 2);
        chk("count", o_count, mq.size());
        chk("full", o_full, mq.size() == DEPTH);
        chk("empty", o_empty, mq.size() == 0);
        if (mq.size() >= 2) begin
            chk("seg_x0", o_x0, mq[0].x);
            chk("seg_y0", o_y0, mq[0].y);
            chk("seg_x1", o_x1, mq[1].x);
            chk("seg_y1", o_y1, mq[1].y);
            chk("seg_color", o_color, mq[1].c);
        end
        popped = 0;
        if (!flush && mq.size() >= 2 && ready) popped = mode ? 1 : 2;
        accept = !flush && push && (mq.size() < DEPTH || popped > 0);
        drop_e = push && !flush && !accept;
        if (flush) begin
            mq.delete();
        end else begin
            repeat (popped) mq.delete(0);
            if (accept) mq.push_back('{x: sx, y: sy, c: sc});
        end
        if (setx) sx = val;
        if (sety) sy = val[7:0];
        if (setcol) sc = val[2:0];
        @(posedge i_clk);
        #1;
        chk("drop", o_drop, drop_e);
        chk("xin", o_xin, sx);
        chk("yin", o_yin, sy);
        chk("cin", o_cin, sc);
    endtask

    task automatic add_point(input logic [8:0] val, input logic mode, input logic ready);
        cyc(1, 1, 1, val, 0, 0, mode, ready);
        cyc(0, 0, 0, '0, 1, 0, mode, ready);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        tbl[0] = '{1'b1, 1'b0, 1'b0, 9'd10,  1'b0, 1'b0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 9'd20,  1'b0, 1'b0, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 9'd5,   1'b0, 1'b0, 0, 0, 0, 0, 0, 0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 9'd0,   1'b1, 1'b0, 1, 0, 0, 0, 0, 0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 9'd100, 1'b0, 1'b0, 1, 0, 0, 0, 0, 0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 9'd50,  1'b0, 1'b0, 1, 0, 0, 0, 0, 0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 9'd2,   1'b0, 1'b0, 1, 0, 0, 0, 0, 0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 9'd0,   1'b1, 1'b1, 2, 10, 20, 100, 50, 2};

        idle_inputs();
        sx = '0; sy = '0; sc = '0;
        i_reset_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_count", o_count, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_drop", o_drop, 0);
        chk("rst_xin", o_xin, 0);
        chk("rst_x0", o_x0, 0);
        chk("rst_color", o_color, 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // Directed table: stage and push two points, no consumer.
        foreach (tbl[i]) begin
            cyc(tbl[i].setx, tbl[i].sety, tbl[i].setcol, tbl[i].val, tbl[i].push, 0, 0, 0);
            chk("tbl_valid", o_valid, tbl[i].ev);
            chk("tbl_count", o_count, tbl[i].ecnt);
            if (tbl[i].ev) begin
                chk("tbl_x0", o_x0, tbl[i].ex0);
                chk("tbl_y0", o_y0, tbl[i].ey0);
                chk("tbl_x1", o_x1, tbl[i].ex1);
                chk("tbl_y1", o_y1, tbl[i].ey1);
                chk("tbl_color", o_color, tbl[i].ec);
            end
        end

        // Mode 0: four points give two disjoint segments.
        add_point(9'd33, 0, 0);
        add_point(9'h1C6, 0, 0);
        chk("m0_cnt4", o_count, 4);
        cyc(0, 0, 0, '0, 0, 0, 0, 1);
        chk("m0_cnt2", o_count, 2);
        chk("m0_x0_c", o_x0, 33);
        cyc(0, 0, 0, '0, 0, 0, 0, 1);
        chk("m0_cnt0", o_count, 0);
        chk("m0_valid0", o_valid, 0);

        // Mode 1: three points give two chained segments, last point stays.
        add_point(9'd61, 1, 0);
        add_point(9'd72, 1, 0);
        add_point(9'd83, 1, 0);
        cyc(0, 0, 0, '0, 0, 0, 1, 1);
        chk("m1_cnt2", o_count, 2);
        chk("m1_x0_b", o_x0, 72);
        cyc(0, 0, 0, '0, 0, 0, 1, 1);
        chk("m1_cnt1", o_count, 1);
        chk("m1_valid0", o_valid, 0);
        cyc(0, 0, 0, '0, 0, 0, 1, 1);
        chk("m1_keep", o_count, 1);

        // Full: rejected push pulses drop once; push with pop is accepted.
        add_point(9'd90, 1, 0);
        add_point(9'd91, 1, 0);
        add_point(9'd92, 1, 0);
        chk("full_flag", o_full, 1);
        cyc(0, 0, 0, '0, 1, 0, 1, 0);
        chk("full_drop", o_drop, 1);
        chk("full_cnt", o_count, 4);
        cyc(0, 0, 0, '0, 0, 0, 1, 0);
        chk("drop_pulse", o_drop, 0);
        cyc(0, 0, 0, '0, 1, 0, 1, 1);
        chk("pushpop_drop", o_drop, 0);
        chk("pushpop_cnt", o_count, 4);
        cyc(0, 0, 0, '0, 0, 1, 0, 0);
        chk("flush_cnt", o_count, 0);

        // Set and push in one cycle: pushed point carries the old x.
        cyc(1, 1, 1, 9'h0AB, 0, 0, 0, 0);
        cyc(1, 0, 0, 9'd300, 1, 0, 0, 0);
        chk("same_xin", o_xin, 300);
        cyc(0, 0, 0, '0, 1, 0, 0, 0);
        chk("same_x0", o_x0, 171);
        chk("same_x1", o_x1, 300);
        cyc(0, 0, 0, '0, 0, 0, 0, 1);

        // Pointer wrap under continuous polyline consumption.
        for (int i = 0; i < 8; i++) add_point(9'(i * 37 + 5), 1, 1);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 9'($urandom),
                1'($urandom), ($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom));
        end

        // Asynchronous reset mid-stream with three points held.
        cyc(0, 0, 0, '0, 0, 1, 0, 0);
        add_point(9'd11, 0, 0);
        add_point(9'd22, 0, 0);
        add_point(9'd33, 0, 0);
        chk("pre_rst_cnt", o_count, 3);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("arst_count", o_count, 0);
        chk("arst_empty", o_empty, 1);
        chk("arst_valid", o_valid, 0);
        chk("arst_x0", o_x0, 0);
        chk("arst_y1", o_y1, 0);
        chk("arst_xin", o_xin, 0);
        chk("arst_cin", o_cin, 0);
        mq.delete();
        sx = '0; sy = '0; sc = '0;
        idle_inputs();
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // Flush beats a push into a full FIFO without raising drop.
        for (int i = 0; i < 4; i++) add_point(9'(i + 200), 0, 0);
        cyc(0, 0, 0, '0, 1, 1, 0, 0);
        chk("flush_push_cnt", o_count, 0);
        chk("flush_push_drop", o_drop, 0);
        chk("flush_push_empty", o_empty, 1);
        cyc(0, 0, 0, '0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
